vga_capture: RTL and testbench

- Receive end of the board's 800x600 VGA link.
- Samples RGB332 pixels plus active-low hsync/vsync on a pixel-enable strobe, recovers raster position, checks timing against expected totals, and emits a coordinate-tagged pixel stream.
- Used for loopback self-test of the shader output and as a frame-grab front end.
- All inputs are synchronous to clock; there is no CDC.

---
 rtl/vga_capture_pkg.sv | 37 +++
 rtl/vga_sync_edge.sv | 23 ++
 rtl/vga_capture.sv | 194 +++++++++++++++++++
 tb/tb_vga_capture.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture path: FSM states, default 800x600
// raster timing (shared with the generator side) and CRC-16-CCITT constants.
package vga_capture_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } cap_state_t;

    localparam int H_TOTAL_DEF  = 1056;
    localparam int V_TOTAL_DEF  = 628;
    localparam int H_BP_DEF     = 88;
    localparam int V_BP_DEF     = 22;
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    localparam logic [11:0] POS_MAX = 12'hFFF;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One byte of CRC-16-CCITT, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Rising-edge detector for an active-low sync line, advanced on pixel_en.
// Ports: clock, reset (async high), pixel_en, sync (level), rise (pulse).
module vga_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pixel_en,
    input  logic sync,
    output logic rise
);

    logic prev;

    // Idle-high so a line that is already high at reset is not a rise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            prev <= 1'b1;
        else if (pixel_en)
            prev <= sync;
    end

    assign rise = pixel_en & ~prev & sync;

endmodule

// File: rtl/vga_capture.sv
// VGA receive front end: recovers raster position from hsync/vsync, verifies
// line/frame totals, and emits coordinate-tagged RGB332 pixels once locked.
// Ports: clock, reset, pixel_en, hsync_in, vsync_in, red/green/blue_in in;
//   pix_valid, pix_x, pix_y, pix_data, line_start, frame_start, locked,
//   sync_err, h_total_meas, v_total_meas out.
// VGA_CAPTURE_CRC_EN adds frame_crc / crc_valid (per-frame CRC-16-CCITT).
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [7:0]  pix_data,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [11:0] h_total_meas,
`ifdef VGA_CAPTURE_CRC_EN
    output logic [11:0] v_total_meas,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`else
    output logic [11:0] v_total_meas
`endif
);

    localparam logic [12:0] H_LEN = 13'(H_TOTAL);
    localparam logic [11:0] V_LEN = 12'(V_TOTAL);
    localparam logic [11:0] X_LO  = 12'(H_BP);
    localparam logic [11:0] X_HI  = 12'(H_BP + H_ACTIVE);
    localparam logic [11:0] Y_LO  = 12'(V_BP + 1);
    localparam logic [11:0] Y_HI  = 12'(V_BP + V_ACTIVE);

    cap_state_t  state, state_nx;
    logic        skip_h, skip_h_nx;
    logic        h_rise, v_rise;
    logic [11:0] h_pos, h_cur;
    logic [11:0] line_idx, line_cur;
    logic [12:0] h_len;
    logic        h_bad, v_bad, sat_hit, fail;
    logic        active, emit;
    logic [11:0] x_cur, y_cur;
    logic [7:0]  pix_byte;

    vga_sync_edge u_hs (
        .clock    (clock),
        .reset    (reset),
        .pixel_en (pixel_en),
        .sync     (hsync_in),
        .rise     (h_rise)
    );

    vga_sync_edge u_vs (
        .clock    (clock),
        .reset    (reset),
        .pixel_en (pixel_en),
        .sync     (vsync_in),
        .rise     (v_rise)
    );

    assign pix_byte = {red_in, green_in, blue_in};

    // Position of the current sample plus the timing checks it triggers.
    always_comb begin
        h_len    = {1'b0, h_pos} + 13'd1;
        h_cur    = h_pos;
        line_cur = line_idx;
        if (h_rise)
            h_cur = '0;
        else if (h_pos != POS_MAX)
            h_cur = h_pos + 12'd1;
        // vsync wins: a coincident hsync rise lands on line 0.
        if (v_rise)
            line_cur = '0;
        else if (h_rise && line_idx != POS_MAX)
            line_cur = line_idx + 12'd1;
        // The line in progress when measuring starts may be partial.
        h_bad   = h_rise && !(state == MEASURE && skip_h)
                  && (h_len != H_LEN);
        v_bad   = v_rise && (line_idx != V_LEN);
        sat_hit = pixel_en && !h_rise && (h_pos == POS_MAX - 12'd1);
        fail    = (state != SEARCH) && (h_bad || v_bad || sat_hit);
        active  = (h_cur >= X_LO) && (h_cur < X_HI)
                  && (line_cur >= Y_LO) && (line_cur <= Y_HI);
        emit    = pixel_en && (state == LOCKED) && !fail && active;
        x_cur   = h_cur - X_LO;
        y_cur   = line_cur - Y_LO;
    end

    always_comb begin
        state_nx  = state;
        skip_h_nx = skip_h;
        if (fail) begin
            state_nx = SEARCH;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (v_rise) begin
                        state_nx  = MEASURE;
                        skip_h_nx = 1'b1;
                    end
                end
                MEASURE: begin
                    if (v_rise)
                        state_nx = LOCKED;
                    else if (h_rise)
                        skip_h_nx = 1'b0;
                end
                LOCKED:  state_nx = LOCKED;
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            skip_h       <= 1'b0;
            h_pos        <= '0;
            line_idx     <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_data     <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            skip_h      <= skip_h_nx;
            pix_valid   <= emit;
            line_start  <= emit && (x_cur == '0);
            frame_start <= emit && (x_cur == '0) && (y_cur == '0);
            sync_err    <= fail;
            if (pixel_en) begin
                h_pos    <= h_cur;
                line_idx <= line_cur;
            end
            if (h_rise)
                h_total_meas <= h_len[11:0];
            if (v_rise)
                v_total_meas <= line_idx;
            if (emit) begin
                pix_x    <= x_cur;
                pix_y    <= y_cur;
                pix_data <= pix_byte;
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc;

    // Only a frame that was LOCKED end to end reaches a clean vsync
    // rise while still LOCKED, so that alone qualifies crc_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc       <= CRC_INIT;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= v_rise && (state == LOCKED) && !fail;
            if (v_rise) begin
                if ((state == LOCKED) && !fail)
                    frame_crc <= crc;
                crc <= CRC_INIT;
            end else if (emit) begin
                crc <= crc16_byte(crc, pix_byte);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a scaled-down raster with a
// per-sample behavioural model of lock state, coordinates and CRC.
module tb_vga_capture;

    localparam int HT   = 40;
    localparam int VT   = 30;
    localparam int HB   = 6;
    localparam int VB   = 3;
    localparam int HA   = 24;
    localparam int VA   = 20;
    localparam int HS_W = 4;
    localparam int VS_H = HT - HS_W;
    localparam int NPIX = HA * VA;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [2:0]  red_in = '0;
    logic [2:0]  green_in = '0;
    logic [1:0]  blue_in = '0;
    logic        pix_valid;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [7:0]  pix_data;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [11:0] h_total_meas;
    logic [11:0] v_total_meas;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_capture #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_BP     (HB),
        .V_BP     (VB),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_en     (pixel_en),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .red_in       (red_in),
        .green_in     (green_in),
        .blue_in      (blue_in),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .locked       (locked),
        .sync_err     (sync_err),
        .h_total_meas (h_total_meas),
`ifdef VGA_CAPTURE_CRC_EN
        .v_total_meas (v_total_meas),
        .frame_crc    (frame_crc),
        .crc_valid    (crc_valid)
`else
        .v_total_meas (v_total_meas)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: 0 = hunting, 1 = measuring, 2 = locked.
    int          m_state;
    bit          m_skip;
    int          m_h;
    int          m_lines;
    bit          m_prev_h;
    bit          m_prev_v;
    int          m_hmeas;
    int          m_vmeas;
    logic [15:0] m_crc;
    logic [15:0] m_fcrc;

    int          gap_mode;
    int          dut_valids = 0;
    int          dut_fstarts = 0;
    int          dut_errs = 0;
    int          err_h = 0;
    int          err_v = 0;
    logic [15:0] crc_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_ccitt(input logic [15:0] c,
                                              input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_skip   = 0;
        m_h      = 0;
        m_lines  = 0;
        m_prev_h = 1;
        m_prev_v = 1;
        m_hmeas  = 0;
        m_vmeas  = 0;
        m_crc    = 16'hFFFF;
        m_fcrc   = 16'h0000;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"}, pix_valid, 0);
        check({pfx, "_x"}, pix_x, 0);
        check({pfx, "_y"}, pix_y, 0);
        check({pfx, "_data"}, pix_data, 0);
        check({pfx, "_lstart"}, line_start, 0);
        check({pfx, "_fstart"}, frame_start, 0);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_sync_err"}, sync_err, 0);
        check({pfx, "_hmeas"}, h_total_meas, 0);
        check({pfx, "_vmeas"}, v_total_meas, 0);
    endtask

    // One pixel_en sample (preceded by idle clocks) checked against the model.
    task automatic sample(input bit hs, input bit vs, input logic [7:0] d);
        int idle;
        bit hr, vr, fl, ev, ec;
        int hn, ln, x, y, hl;
        idle = (gap_mode == 0) ? 2 :
               (gap_mode == 1) ? int'($urandom_range(1, 0)) : 0;
        repeat (idle) begin
            @(posedge clock);
            #1;
            check("idle_valid", pix_valid, 0);
            check("idle_sync_err", sync_err, 0);
        end
        @(negedge clock);
        pixel_en = 1'b1;
        hsync_in = hs;
        vsync_in = vs;
        {red_in, green_in, blue_in} = d;

        hr = !m_prev_h && hs;
        vr = !m_prev_v && vs;
        m_prev_h = hs;
        m_prev_v = vs;
        hl = m_h + 1;
        hn = hr ? 0 : (m_h >= 4095 ? 4095 : m_h + 1);
        ln = vr ? 0 : (hr ? (m_lines >= 4095 ? 4095 : m_lines + 1) : m_lines);
        fl = 0;
        if (m_state != 0) begin
            if (hr && !(m_state == 1 && m_skip) && hl != HT) fl = 1;
            if (vr && m_lines != VT) fl = 1;
            if (!hr && m_h == 4094) fl = 1;
        end
        x  = hn - HB;
        y  = ln - VB - 1;
        ev = (m_state == 2) && !fl && x >= 0 && x < HA && y >= 0 && y < VA;
        ec = vr && (m_state == 2) && !fl;
        if (hr) m_hmeas = hl & 'hFFF;
        if (vr) m_vmeas = m_lines;
        if (vr) begin
            if (ec) m_fcrc = m_crc;
            m_crc = 16'hFFFF;
        end else if (ev) begin
            m_crc = crc_ccitt(m_crc, d);
        end
        if (fl) begin
            m_state = 0;
        end else if (m_state == 0 && vr) begin
            m_state = 1;
            m_skip  = 1;
        end else if (m_state == 1 && vr) begin
            m_state = 2;
        end else if (m_state == 1 && hr) begin
            m_skip = 0;
        end
        m_h     = hn;
        m_lines = ln;

        @(posedge clock);
        #1;
        pixel_en = 1'b0;
        check("pix_valid", pix_valid, ev);
        if (ev) begin
            check("pix_x", pix_x, x);
            check("pix_y", pix_y, y);
            check("pix_data", pix_data, d);
            check("line_start", line_start, x == 0);
            check("frame_start", frame_start, x == 0 && y == 0);
        end else begin
            check("line_start_idle", line_start, 0);
            check("frame_start_idle", frame_start, 0);
        end
        check("sync_err", sync_err, fl);
        check("locked", locked, m_state == 2);
        check("h_total_meas", h_total_meas, m_hmeas);
        check("v_total_meas", v_total_meas, m_vmeas);
`ifdef VGA_CAPTURE_CRC_EN
        check("crc_valid", crc_valid, ec);
        if (ec) check("frame_crc", frame_crc, m_fcrc);
        if (crc_valid) crc_q.push_back(frame_crc);
`endif
        if (pix_valid) dut_valids++;
        if (frame_start) dut_fstarts++;
        if (sync_err) begin
            dut_errs++;
            err_h = int'(h_total_meas);
            err_v = int'(v_total_meas);
        end
    endtask

    task automatic do_reset_mid();
        check("pre_reset_locked", locked, 1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // pat: 0 = x^y, 1 = random, 2 = zero. short_l gets one sample fewer.
    task automatic frame(input int nlines, input int short_l, input int pat,
                         input int rst_l, output int nvalid);
        int len, x, y, v0;
        bit hs, vs;
        logic [7:0] d;
        v0 = dut_valids;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                hs = !(h >= len - HS_W);
                vs = !((l == 0 && h < VS_H) || l >= nlines - 2);
                x  = h - HB;
                y  = l - VB - 1;
                if (pat == 0)      d = 8'(x ^ y);
                else if (pat == 1) d = 8'($urandom);
                else               d = 8'h00;
                if (l == rst_l && h == HB + HA / 2) do_reset_mid();
                sample(hs, vs, d);
            end
        end
        nvalid = dut_valids - v0;
    endtask

    initial begin
        int n, e0, fs0;
`ifdef VGA_CAPTURE_CRC_EN
        int q0;
        logic [15:0] ref_zero;
`endif
        model_reset();
        gap_mode = 0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        frame(VT, -1, 0, -1, n);
        check("f0_pixels", n, 0);
        check("f0_locked", locked, 0);
        frame(VT, -1, 0, -1, n);
        check("f1_locked", locked, 1);
        fs0 = dut_fstarts;
        frame(VT, -1, 0, -1, n);
        check("f2_pixels", n, NPIX);
        check("f2_frame_starts", dut_fstarts - fs0, 1);

        gap_mode = 1;
        e0 = dut_errs;
        frame(VT, 10, 1, -1, n);
        check("short_line_errs", dut_errs - e0, 1);
        check("short_line_locked", locked, 0);
        frame(VT, -1, 1, -1, n);
        check("short_next_pixels", n, 0);
        frame(VT, -1, 1, -1, n);
        check("short_relock_pixels", n, NPIX);

        frame(VT - 1, -1, 1, -1, n);
        e0 = dut_errs;
        frame(VT, -1, 1, -1, n);
        check("short_frame_errs", dut_errs - e0, 1);
        check("short_frame_hmeas", err_h, HT);
        check("short_frame_vmeas", err_v, VT - 1);
        check("short_frame_p1_pixels", n, 0);
        frame(VT, -1, 1, -1, n);
        check("short_frame_p2_pixels", n, 0);
        frame(VT, -1, 1, -1, n);
        check("short_frame_relock", n, NPIX);

        frame(VT, -1, 1, VB + 6, n);
        check("reset_locked_after", locked, 0);
        frame(VT, -1, 1, -1, n);
        check("reset_p1_pixels", n, 0);
        frame(VT, -1, 1, -1, n);
        check("reset_relock_pixels", n, NPIX);

        gap_mode = 2;
        e0 = dut_errs;
        for (int i = 0; i < 5000; i++) sample(1'b0, 1'b0, 8'($urandom));
        check("sat_errs", dut_errs - e0, 1);
        check("sat_locked", locked, 0);
        gap_mode = 1;
        frame(VT, -1, 1, -1, n);
        check("sat_p1_pixels", n, 0);
        frame(VT, -1, 1, -1, n);
        check("sat_relock_pixels", n, NPIX);

`ifdef VGA_CAPTURE_CRC_EN
        ref_zero = 16'hFFFF;
        for (int i = 0; i < NPIX; i++) ref_zero = crc_ccitt(ref_zero, 8'h00);
        q0 = crc_q.size();
        for (int f = 0; f < 3; f++) frame(VT, -1, 2, -1, n);
        check("crc_count", crc_q.size() - q0, 3);
        if (crc_q.size() - q0 == 3) begin
            check("crc_zero_a", crc_q[q0 + 1], ref_zero);
            check("crc_zero_b", crc_q[q0 + 2], ref_zero);
            check("crc_repeat", crc_q[q0 + 2], crc_q[q0 + 1]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
